// File: rtl/dip_morph_ctrl.sv
// Frame-synchronous mode controller for the erosion/dilation engines.
// It tracks the pixel position and switches mode only at frame boundaries.
// It feeds pixels to the active engine and merges the engine and bypass
// write streams into a single SDRAM write port.
module dip_morph_ctrl #(
    parameter logic [15:0] CNT_COL_MAX = 16'd1023,
    parameter logic [15:0] CNT_ROW_MAX = 16'd767
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  mode_req,
    input  logic        mode_req_vld,
    input  logic        pix_en,
    input  logic [7:0]  pix_data,
    output logic        ero_en,
    output logic        dil_en,
    output logic [7:0]  eng_data,
    input  logic        ero_wr_en,
    input  logic [15:0] ero_wr_data,
    input  logic        dil_wr_en,
    input  logic [15:0] dil_wr_data,
    output logic        sdram_wr_en,
    output logic [15:0] sdram_wr_data,
    output logic [1:0]  mode_cur,
    output logic        frame_done,
    output logic [7:0]  frame_cnt,
    output logic        collision
);

    localparam int unsigned CNT_W  = 16;
    localparam int unsigned MODE_W = 2;
    localparam int unsigned PIX_W  = 8;
    localparam int unsigned WR_W   = 16;
    localparam int unsigned FRM_W  = 8;

    localparam logic [MODE_W-1:0] MODE_BYP = 2'b00;
    localparam logic [MODE_W-1:0] MODE_ERO = 2'b01;
    localparam logic [MODE_W-1:0] MODE_DIL = 2'b10;
    localparam logic [MODE_W-1:0] MODE_RSV = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_END  = 2'b10
    } state_t;

    state_t              state_q;
    state_t              state_d;

    logic [CNT_W-1:0]    col;
    logic [CNT_W-1:0]    row;
    logic [CNT_W-1:0]    col_d;
    logic [CNT_W-1:0]    row_d;
    logic                last_pix_c;
    logic                boundary_c;

    logic [MODE_W-1:0]   pend_mode;
    logic                pend_flag;
    logic [MODE_W-1:0]   pend_mode_d;
    logic                pend_flag_d;
    logic [MODE_W-1:0]   mode_d;

    logic                byp_en;
    logic                multi_wr_c;
    logic                any_wr_c;
    logic [WR_W-1:0]     merge_data_c;

    // The reserved encoding behaves as bypass.
    function automatic logic [MODE_W-1:0] map_mode(input logic [MODE_W-1:0] m);
        return (m == MODE_RSV) ? MODE_BYP : m;
    endfunction

    // Position decode: the incoming pixel is the last one of the frame.
    assign last_pix_c = (col == CNT_COL_MAX) && (row == CNT_ROW_MAX);
    assign boundary_c = (state_q == ST_IDLE) || (state_q == ST_END);

    // Next column/row position for the accepted pixel.
    always_comb begin
        col_d = col;
        row_d = row;
        if (pix_en) begin
            if (col == CNT_COL_MAX) begin
                col_d = '0;
                row_d = (row == CNT_ROW_MAX) ? '0 : row + CNT_W'(1);
            end else begin
                col_d = col + CNT_W'(1);
            end
        end
    end

    // Frame FSM next state; END lasts one cycle per completed frame.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (pix_en) begin
                    state_d = last_pix_c ? ST_END : ST_RUN;
                end
            end
            ST_RUN: begin
                if (pix_en && last_pix_c) begin
                    state_d = ST_END;
                end
            end
            ST_END: begin
                state_d = (pix_en && last_pix_c) ? ST_END : ST_RUN;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Mode request handling: apply at a boundary, otherwise hold as pending.
    always_comb begin
        mode_d      = mode_cur;
        pend_mode_d = pend_mode;
        pend_flag_d = pend_flag;
        if (boundary_c) begin
            if (mode_req_vld) begin
                mode_d = map_mode(mode_req);
            end else if (pend_flag) begin
                mode_d = map_mode(pend_mode);
            end
            pend_flag_d = 1'b0;
        end else if (mode_req_vld) begin
            pend_mode_d = mode_req;
            pend_flag_d = 1'b1;
        end
    end

    // Write merge: ero has priority over dil, and dil over bypass.
    always_comb begin
        any_wr_c     = ero_wr_en | dil_wr_en | byp_en;
        multi_wr_c   = (ero_wr_en & dil_wr_en) | (ero_wr_en & byp_en) | (dil_wr_en & byp_en);
        merge_data_c = {WR_W{eng_data[PIX_W-1]}};
        if (ero_wr_en) begin
            merge_data_c = ero_wr_data;
        end else if (dil_wr_en) begin
            merge_data_c = dil_wr_data;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Position counters, mode registers and frame bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col        <= '0;
            row        <= '0;
            pend_mode  <= '0;
            pend_flag  <= 1'b0;
            mode_cur   <= MODE_BYP;
            frame_done <= 1'b0;
            frame_cnt  <= '0;
        end else begin
            col        <= col_d;
            row        <= row_d;
            pend_mode  <= pend_mode_d;
            pend_flag  <= pend_flag_d;
            mode_cur   <= mode_d;
            frame_done <= (state_d == ST_END);
            if (state_d == ST_END) begin
                frame_cnt <= frame_cnt + FRM_W'(1);
            end
        end
    end

    // Engine feed stage; enables use the mode in force when the pixel arrives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            eng_data <= '0;
            ero_en   <= 1'b0;
            dil_en   <= 1'b0;
            byp_en   <= 1'b0;
        end else begin
            eng_data <= pix_data;
            ero_en   <= pix_en && (mode_cur == MODE_ERO);
            dil_en   <= pix_en && (mode_cur == MODE_DIL);
            byp_en   <= pix_en && (mode_cur == MODE_BYP);
        end
    end

    // Registered SDRAM write port and sticky writer-conflict flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sdram_wr_en   <= 1'b0;
            sdram_wr_data <= '0;
            collision     <= 1'b0;
        end else begin
            sdram_wr_en   <= any_wr_c;
            sdram_wr_data <= merge_data_c;
            collision     <= collision | multi_wr_c;
        end
    end

endmodule

// File: tb/tb_dip_morph_ctrl.sv
// Directed bench for dip_morph_ctrl using a 4x2 frame.
module tb_dip_morph_ctrl;

    logic        clk;
    logic        rst_n;
    logic [1:0]  mode_req;
    logic        mode_req_vld;
    logic        pix_en;
    logic [7:0]  pix_data;
    logic        ero_en;
    logic        dil_en;
    logic [7:0]  eng_data;
    logic        ero_wr_en;
    logic [15:0] ero_wr_data;
    logic        dil_wr_en;
    logic [15:0] dil_wr_data;
    logic        sdram_wr_en;
    logic [15:0] sdram_wr_data;
    logic [1:0]  mode_cur;
    logic        frame_done;
    logic [7:0]  frame_cnt;
    logic        collision;

    int n_checks;
    int n_errors;

    dip_morph_ctrl #(
        .CNT_COL_MAX(16'd3),
        .CNT_ROW_MAX(16'd1)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .mode_req      (mode_req),
        .mode_req_vld  (mode_req_vld),
        .pix_en        (pix_en),
        .pix_data      (pix_data),
        .ero_en        (ero_en),
        .dil_en        (dil_en),
        .eng_data      (eng_data),
        .ero_wr_en     (ero_wr_en),
        .ero_wr_data   (ero_wr_data),
        .dil_wr_en     (dil_wr_en),
        .dil_wr_data   (dil_wr_data),
        .sdram_wr_en   (sdram_wr_en),
        .sdram_wr_data (sdram_wr_data),
        .mode_cur      (mode_cur),
        .frame_done    (frame_done),
        .frame_cnt     (frame_cnt),
        .collision     (collision)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ero_en"},   32'(ero_en),        32'd0);
        chk({tag, "_dil_en"},   32'(dil_en),        32'd0);
        chk({tag, "_eng_data"}, 32'(eng_data),      32'd0);
        chk({tag, "_wr_en"},    32'(sdram_wr_en),   32'd0);
        chk({tag, "_wr_data"},  32'(sdram_wr_data), 32'd0);
        chk({tag, "_mode"},     32'(mode_cur),      32'd0);
        chk({tag, "_fdone"},    32'(frame_done),    32'd0);
        chk({tag, "_fcnt"},     32'(frame_cnt),     32'd0);
        chk({tag, "_coll"},     32'(collision),     32'd0);
    endtask

    task automatic do_reset();
        mode_req     = 2'b00;
        mode_req_vld = 1'b0;
        pix_en       = 1'b0;
        pix_data     = 8'h00;
        ero_wr_en    = 1'b0;
        ero_wr_data  = 16'h0000;
        dil_wr_en    = 1'b0;
        dil_wr_data  = 16'h0000;
        rst_n        = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        logic [7:0] pix31 [3];
        logic [7:0] pix36 [8];
        n_checks = 0;
        n_errors = 0;
        pix31 = '{8'h80, 8'h00, 8'hFF};
        pix36 = '{8'h80, 8'h01, 8'hC0, 8'h7F, 8'hFF, 8'h00, 8'h81, 8'h10};

        // Reset state, with inputs toggling to prove the reset dominates.
        do_reset();
        rst_n    = 1'b0;
        pix_en   = 1'b1;
        pix_data = 8'hAA;
        tick();
        chk_all_zero("rst");
        pix_en = 1'b0;
        rst_n  = 1'b1;

        // Dilate requested in IDLE, three pixels.
        do_reset();
        mode_req     = 2'b10;
        mode_req_vld = 1'b1;
        tick();
        mode_req_vld = 1'b0;
        chk("dil_mode", 32'(mode_cur), 32'd2);
        for (int i = 0; i < 3; i++) begin
            pix_en   = 1'b1;
            pix_data = pix31[i];
            tick();
            chk("dil_en",   32'(dil_en),   32'd1);
            chk("dil_ero",  32'(ero_en),   32'd0);
            chk("dil_data", 32'(eng_data), 32'(pix31[i]));
        end
        pix_en = 1'b0;
        tick();
        chk("dil_en_off", 32'(dil_en),      32'd0);
        chk("dil_no_wr",  32'(sdram_wr_en), 32'd0);

        // Bypass path: msb replicated, two-cycle latency.
        do_reset();
        pix_en   = 1'b1;
        pix_data = 8'h80;
        tick();
        chk("byp_lat1", 32'(sdram_wr_en), 32'd0);
        pix_data = 8'h7F;
        tick();
        pix_en = 1'b0;
        chk("byp_en0",   32'(sdram_wr_en),   32'd1);
        chk("byp_data0", 32'(sdram_wr_data), 32'hFFFF);
        tick();
        chk("byp_en1",   32'(sdram_wr_en),   32'd1);
        chk("byp_data1", 32'(sdram_wr_data), 32'h0000);
        tick();
        chk("byp_off",   32'(sdram_wr_en),   32'd0);

        // Erode requested mid-frame is held until the frame boundary.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            pix_en       = 1'b1;
            pix_data     = 8'(i);
            mode_req     = 2'b01;
            mode_req_vld = (i == 2);
            tick();
            chk("hold_mode",  32'(mode_cur),   32'd0);
            chk("hold_fdone", 32'(frame_done), 32'(i == 7));
        end
        chk("hold_ero_last", 32'(ero_en), 32'd0);
        pix_en       = 1'b0;
        mode_req_vld = 1'b0;
        tick();
        chk("hold_fdone_end", 32'(frame_done), 32'd0);
        chk("hold_mode_new",  32'(mode_cur),   32'd1);
        chk("hold_fcnt",      32'(frame_cnt),  32'd1);
        pix_en = 1'b1;
        tick();
        pix_en = 1'b0;
        chk("hold_ero_on", 32'(ero_en), 32'd1);

        // Two mid-frame requests: last one wins.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            pix_en       = 1'b1;
            mode_req     = (i == 1) ? 2'b01 : 2'b10;
            mode_req_vld = (i == 1) || (i == 4);
            tick();
            chk("last_mode", 32'(mode_cur), 32'd0);
        end
        pix_en       = 1'b0;
        mode_req_vld = 1'b0;
        tick();
        chk("last_applied", 32'(mode_cur),  32'd2);
        chk("last_fcnt",    32'(frame_cnt), 32'd1);

        // Engine write merge and sticky collision.
        do_reset();
        ero_wr_en   = 1'b1;
        ero_wr_data = 16'h1111;
        tick();
        chk("mrg_ero_en",   32'(sdram_wr_en),   32'd1);
        chk("mrg_ero_data", 32'(sdram_wr_data), 32'h1111);
        chk("mrg_ero_coll", 32'(collision),     32'd0);
        ero_wr_en   = 1'b0;
        dil_wr_en   = 1'b1;
        dil_wr_data = 16'h2222;
        tick();
        chk("mrg_dil_data", 32'(sdram_wr_data), 32'h2222);
        chk("mrg_dil_coll", 32'(collision),     32'd0);
        ero_wr_en = 1'b1;
        tick();
        chk("mrg_both_en",   32'(sdram_wr_en),   32'd1);
        chk("mrg_both_data", 32'(sdram_wr_data), 32'h1111);
        chk("mrg_both_coll", 32'(collision),     32'd1);
        ero_wr_en = 1'b0;
        dil_wr_en = 1'b0;
        tick();
        chk("mrg_idle_en", 32'(sdram_wr_en), 32'd0);
        tick();
        chk("mrg_sticky",  32'(collision),   32'd1);

        // Reset in the middle of a frame.
        do_reset();
        mode_req     = 2'b10;
        mode_req_vld = 1'b1;
        tick();
        mode_req_vld = 1'b0;
        for (int i = 0; i < 5; i++) begin
            pix_en   = 1'b1;
            pix_data = 8'hF0;
            tick();
        end
        chk("mid_dil_before", 32'(dil_en), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("mid_rst");
        pix_en = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            pix_en   = 1'b1;
            pix_data = pix36[i];
            tick();
            chk("post_mode",  32'(mode_cur),    32'd0);
            chk("post_fdone", 32'(frame_done),  32'(i == 7));
            chk("post_wr_en", 32'(sdram_wr_en), 32'(i >= 1));
            if (i >= 1) begin
                chk("post_wr_data", 32'(sdram_wr_data), 32'({16{pix36[i-1][7]}}));
            end
        end
        pix_en = 1'b0;
        tick();
        chk("post_fcnt", 32'(frame_cnt), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
